// File: rtl/csr_commit_pkg.sv
// Shared definitions for the CSR commit back-end: exception code width,
// the codes the commit stage handles specially, and the per-stage record
// carried through E2 and WB.
package csr_commit_pkg;

   localparam int unsigned EXCEPTION_W = 6;

   typedef logic [EXCEPTION_W-1:0] exc_code_t;

   localparam exc_code_t EXCEPTION_INTERRUPT = 6'h20;
   localparam exc_code_t EXCEPTION_FENCE     = 6'h34;

   // Exception code plus its trap value (bad address or opcode).
   typedef struct packed {
      exc_code_t   code;
      logic [31:0] tval;
   } exc_t;

   // One in-flight instruction as held in E2 or WB.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [11:0] waddr;
      logic        write;
      logic [31:0] wdata;
      exc_t        exc;
   } stage_t;

   // A CSR write may commit with no exception or alongside a fence-class
   // redirect; every other (trap-class) code suppresses it.
   function automatic logic write_permitted(input exc_code_t code);
      return (code == '0) || (code == EXCEPTION_FENCE);
   endfunction

endpackage

// File: rtl/csr_commit_if.sv
// Bus bundle between the issue/E1 pipeline, the CSR unit and csr_commit.
//   slave  : csr_commit side (E1 results, E2 memory fault and control in,
//            csr_writeback_* / squash / interrupt inhibit out)
//   master : the surrounding pipeline / CSR unit side
interface csr_commit_if;
   import csr_commit_pkg::*;

   logic        e1_valid_i;
   logic [31:0] e1_pc_i;
   logic [31:0] e1_opcode_i;
   exc_code_t   e1_exception_i;
   logic [31:0] e1_badaddr_i;
   logic [31:0] csr_result_e1_value_i;
   logic        csr_result_e1_write_i;
   logic [31:0] csr_result_e1_wdata_i;
   exc_code_t   csr_result_e1_exception_i;
   exc_code_t   mem_exception_e2_i;
   logic [31:0] mem_badaddr_e2_i;
   logic        stall_i;
   logic        take_interrupt_i;
   logic        branch_csr_request_i;

   logic        csr_writeback_write_o;
   logic [11:0] csr_writeback_waddr_o;
   logic [31:0] csr_writeback_wdata_o;
   exc_code_t   csr_writeback_exception_o;
   logic [31:0] csr_writeback_exception_pc_o;
   logic [31:0] csr_writeback_exception_addr_o;
   logic        squash_o;
   logic        interrupt_inhibit_o;

   modport slave (
      input  e1_valid_i, e1_pc_i, e1_opcode_i, e1_exception_i, e1_badaddr_i,
             csr_result_e1_value_i, csr_result_e1_write_i, csr_result_e1_wdata_i,
             csr_result_e1_exception_i, mem_exception_e2_i, mem_badaddr_e2_i,
             stall_i, take_interrupt_i, branch_csr_request_i,
      output csr_writeback_write_o, csr_writeback_waddr_o, csr_writeback_wdata_o,
             csr_writeback_exception_o, csr_writeback_exception_pc_o,
             csr_writeback_exception_addr_o, squash_o, interrupt_inhibit_o
   );

   modport master (
      output e1_valid_i, e1_pc_i, e1_opcode_i, e1_exception_i, e1_badaddr_i,
             csr_result_e1_value_i, csr_result_e1_write_i, csr_result_e1_wdata_i,
             csr_result_e1_exception_i, mem_exception_e2_i, mem_badaddr_e2_i,
             stall_i, take_interrupt_i, branch_csr_request_i,
      input  csr_writeback_write_o, csr_writeback_waddr_o, csr_writeback_wdata_o,
             csr_writeback_exception_o, csr_writeback_exception_pc_o,
             csr_writeback_exception_addr_o, squash_o, interrupt_inhibit_o
   );

endinterface

// File: rtl/csr_commit.sv
// csr_commit: E2/WB back-end of the CSR exec unit. Carries registered E1
// CSR results through E2 and WB, merges fetch, CSR-unit and memory faults
// plus pending interrupts, and drives the csr_writeback_* bus.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : csr_commit_if.slave (E1 results and control in, writeback out)
// Parameter SUPPORT_INTERRUPT: 1 injects interrupts at E2->WB, 0 ignores
// take_interrupt_i.
module csr_commit
   import csr_commit_pkg::*;
#(
   parameter int unsigned SUPPORT_INTERRUPT = 1
) (
   input logic        clk_i,
   input logic        rst_i,
   csr_commit_if.slave bus
);

   stage_t e2_q, e2_d;
   stage_t wb_q, wb_d;
   exc_t   e1_exc;
   exc_t   e2_exc;
   logic   irq_take;
   logic   commit;
   logic   squash;

   // The earlier-detected exception wins; the later one is taken only when
   // nothing is pending. With neither present the primary tval is kept.
   function automatic exc_t exc_merge(input exc_t primary, input exc_t secondary);
      if ((primary.code != '0) || (secondary.code == '0))
         return primary;
      return secondary;
   endfunction

   // Only the CSR address field of the opcode is carried forward.
   logic unused_opcode_low;
   assign unused_opcode_low = ^bus.e1_opcode_i[19:0];

   assign commit = wb_q.valid & ~bus.stall_i;
   assign squash = (commit & (wb_q.exc.code != '0)) | bus.branch_csr_request_i;

   always_comb begin
      e1_exc   = exc_merge('{code: bus.csr_result_e1_exception_i, tval: bus.csr_result_e1_value_i},
                           '{code: bus.e1_exception_i,            tval: bus.e1_badaddr_i});
      e2_exc   = exc_merge(e2_q.exc,
                           '{code: bus.mem_exception_e2_i, tval: bus.mem_badaddr_e2_i});
      irq_take = (SUPPORT_INTERRUPT != 0) && bus.take_interrupt_i && e2_q.valid
                 && (e2_exc.code == '0);

      e2_d = e2_q;
      wb_d = wb_q;
      // Flush beats stall: both stages empty and E1 is not captured.
      if (squash) begin
         e2_d.valid = 1'b0;
         wb_d.valid = 1'b0;
      end else if (!bus.stall_i) begin
         e2_d.valid = bus.e1_valid_i;
         e2_d.pc    = bus.e1_pc_i;
         e2_d.waddr = bus.e1_opcode_i[31:20];
         e2_d.write = bus.csr_result_e1_write_i;
         e2_d.wdata = bus.csr_result_e1_wdata_i;
         e2_d.exc   = e1_exc;

         wb_d     = e2_q;
         wb_d.exc = e2_exc;
         if (irq_take) begin
            wb_d.exc.code = EXCEPTION_INTERRUPT;
            wb_d.exc.tval = '0;
            wb_d.write    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         e2_q <= '0;
         wb_q <= '0;
      end else begin
         e2_q <= e2_d;
         wb_q <= wb_d;
      end
   end

   assign bus.csr_writeback_write_o          = commit & wb_q.write & write_permitted(wb_q.exc.code);
   assign bus.csr_writeback_waddr_o          = commit ? wb_q.waddr    : '0;
   assign bus.csr_writeback_wdata_o          = commit ? wb_q.wdata    : '0;
   assign bus.csr_writeback_exception_o      = commit ? wb_q.exc.code : '0;
   assign bus.csr_writeback_exception_pc_o   = commit ? wb_q.pc       : '0;
   assign bus.csr_writeback_exception_addr_o = commit ? wb_q.exc.tval : '0;
   assign bus.squash_o                       = squash;

   assign bus.interrupt_inhibit_o =
        (e2_q.valid & ((e2_q.exc.code != '0) | e2_q.write))
      | (wb_q.valid & ((wb_q.exc.code != '0) | wb_q.write))
      | squash;

endmodule

// File: tb/tb_csr_commit.sv
module tb_csr_commit;

   localparam int unsigned SUPPORT_INTERRUPT = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   csr_commit_if bus();

   csr_commit #(.SUPPORT_INTERRUPT(SUPPORT_INTERRUPT)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: each in-flight instruction keeps its raw sources;
   // the committed cause and tval are derived from the priority rules.
   typedef struct {
      bit          valid;
      logic [31:0] pc, opcode, wdata, csr_val, fetch_addr, mem_addr;
      bit          write, irq;
      logic [5:0]  csr_exc, fetch_exc, mem_exc;
   } instr_t;

   instr_t m_e2, m_wb;

   logic [5:0] exc_pool [8] = '{6'h10, 6'h11, 6'h12, 6'h14, 6'h15, 6'h1b, 6'h33, 6'h34};

   function automatic logic [5:0] cause_no_irq(instr_t i);
      if (i.csr_exc != 0)   return i.csr_exc;
      if (i.fetch_exc != 0) return i.fetch_exc;
      return i.mem_exc;
   endfunction

   function automatic logic [5:0] cause(instr_t i);
      if (cause_no_irq(i) != 0) return cause_no_irq(i);
      return i.irq ? 6'h20 : 6'h00;
   endfunction

   function automatic logic [31:0] tval(instr_t i);
      if (i.csr_exc != 0)   return i.csr_val;
      if (i.fetch_exc != 0) return i.fetch_addr;
      if (i.mem_exc != 0)   return i.mem_addr;
      if (i.irq)            return 32'h0;
      return i.csr_val;
   endfunction

   function automatic bit exp_commit();
      return m_wb.valid && !bus.stall_i;
   endfunction

   function automatic bit exp_squash();
      return (exp_commit() && cause(m_wb) != 0) || bus.branch_csr_request_i;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      bit         cm, wr, sq, inh;
      logic [5:0] c;
      @(negedge clk);
      cm  = exp_commit();
      c   = cause(m_wb);
      wr  = cm && m_wb.write && !m_wb.irq && (c == 6'h00 || c == 6'h34);
      sq  = exp_squash();
      inh = (m_e2.valid && (cause(m_e2) != 0 || m_e2.write))
         || (m_wb.valid && (c != 0 || (m_wb.write && !m_wb.irq)))
         || sq;
      chk("write",   {31'h0, bus.csr_writeback_write_o}, {31'h0, wr});
      chk("waddr",   {20'h0, bus.csr_writeback_waddr_o}, cm ? {20'h0, m_wb.opcode[31:20]} : 32'h0);
      chk("wdata",   bus.csr_writeback_wdata_o, cm ? m_wb.wdata : 32'h0);
      chk("exc",     {26'h0, bus.csr_writeback_exception_o}, cm ? {26'h0, c} : 32'h0);
      chk("exc_pc",  bus.csr_writeback_exception_pc_o, cm ? m_wb.pc : 32'h0);
      chk("exc_addr",bus.csr_writeback_exception_addr_o, cm ? tval(m_wb) : 32'h0);
      chk("squash",  {31'h0, bus.squash_o}, {31'h0, sq});
      chk("inhibit", {31'h0, bus.interrupt_inhibit_o}, {31'h0, inh});
   endtask

   task automatic tick();
      bit     sq;
      instr_t nxt;
      sq = exp_squash();
      @(posedge clk);
      if (rst) begin
         m_e2.valid = 0;
         m_wb.valid = 0;
      end else if (sq) begin
         m_e2.valid = 0;
         m_wb.valid = 0;
      end else if (!bus.stall_i) begin
         nxt          = m_e2;
         nxt.mem_exc  = bus.mem_exception_e2_i;
         nxt.mem_addr = bus.mem_badaddr_e2_i;
         nxt.irq      = (SUPPORT_INTERRUPT != 0) && bus.take_interrupt_i && nxt.valid
                        && cause_no_irq(nxt) == 0;
         m_wb         = nxt;
         m_e2.valid      = bus.e1_valid_i;
         m_e2.pc         = bus.e1_pc_i;
         m_e2.opcode     = bus.e1_opcode_i;
         m_e2.wdata      = bus.csr_result_e1_wdata_i;
         m_e2.csr_val    = bus.csr_result_e1_value_i;
         m_e2.fetch_addr = bus.e1_badaddr_i;
         m_e2.write      = bus.csr_result_e1_write_i;
         m_e2.csr_exc    = bus.csr_result_e1_exception_i;
         m_e2.fetch_exc  = bus.e1_exception_i;
         m_e2.mem_exc    = 6'h0;
         m_e2.mem_addr   = 32'h0;
         m_e2.irq        = 0;
      end
      #1;
   endtask

   task automatic step();
      check_model();
      tick();
   endtask

   task automatic idle();
      bus.e1_valid_i                = 1'b0;
      bus.e1_pc_i                   = '0;
      bus.e1_opcode_i               = '0;
      bus.e1_exception_i            = '0;
      bus.e1_badaddr_i              = '0;
      bus.csr_result_e1_value_i     = '0;
      bus.csr_result_e1_write_i     = 1'b0;
      bus.csr_result_e1_wdata_i     = '0;
      bus.csr_result_e1_exception_i = '0;
      bus.mem_exception_e2_i        = '0;
      bus.mem_badaddr_e2_i          = '0;
      bus.stall_i                   = 1'b0;
      bus.take_interrupt_i          = 1'b0;
      bus.branch_csr_request_i      = 1'b0;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [11:0] csr, input logic [31:0] val,
                        input bit wr, input logic [31:0] wdata, input logic [5:0] cexc);
      idle();
      bus.e1_valid_i                = 1'b1;
      bus.e1_pc_i                   = pc;
      bus.e1_opcode_i               = {csr, 20'h00073};
      bus.csr_result_e1_value_i     = val;
      bus.csr_result_e1_write_i     = wr;
      bus.csr_result_e1_wdata_i     = wdata;
      bus.csr_result_e1_exception_i = cexc;
   endtask

   initial begin
      m_e2 = '{default: '0};
      m_wb = '{default: '0};
      idle();
      rst = 1'b1;
      tick();
      tick();
      check_model();
      chk("rst_pc", bus.csr_writeback_exception_pc_o, 32'h0);
      tick();
      rst = 1'b0;

      // CSRRW mscratch: commits two cycles after E1
      issue(32'h200, 12'h340, 32'h0, 1'b1, 32'h1234, 6'h0);
      step();
      idle();
      step();
      check_model();
      chk("t1_write", {31'h0, bus.csr_writeback_write_o}, 32'h1);
      chk("t1_waddr", {20'h0, bus.csr_writeback_waddr_o}, 32'h340);
      chk("t1_wdata", bus.csr_writeback_wdata_o, 32'h1234);
      chk("t1_exc",   {26'h0, bus.csr_writeback_exception_o}, 32'h0);
      tick();

      // Illegal instruction: opcode reported as tval, write suppressed
      issue(32'h204, 12'h340, 32'hFFFF_FFFF, 1'b1, 32'h55, 6'h12);
      step();
      idle();
      step();
      check_model();
      chk("t2_exc",    {26'h0, bus.csr_writeback_exception_o}, 32'h12);
      chk("t2_addr",   bus.csr_writeback_exception_addr_o, 32'hFFFF_FFFF);
      chk("t2_write",  {31'h0, bus.csr_writeback_write_o}, 32'h0);
      chk("t2_squash", {31'h0, bus.squash_o}, 32'h1);
      tick();

      // Load fault in E2; the younger instruction behind it is dropped
      issue(32'h300, 12'h000, 32'h0, 1'b0, 32'h0, 6'h0);
      step();
      issue(32'h304, 12'h341, 32'h0, 1'b1, 32'h77, 6'h0);
      bus.mem_exception_e2_i = 6'h15;
      bus.mem_badaddr_e2_i   = 32'h8000_0003;
      step();
      idle();
      check_model();
      chk("t3_exc",  {26'h0, bus.csr_writeback_exception_o}, 32'h15);
      chk("t3_addr", bus.csr_writeback_exception_addr_o, 32'h8000_0003);
      tick();
      step();
      check_model();
      chk("t3_drop", bus.csr_writeback_exception_pc_o, 32'h0);
      tick();

      // Interrupt taken as a CSRRW passes from E2 to WB
      issue(32'h100, 12'h340, 32'h0, 1'b1, 32'h9, 6'h0);
      step();
      idle();
      bus.take_interrupt_i = 1'b1;
      check_model();
      chk("t4_inhibit", {31'h0, bus.interrupt_inhibit_o}, 32'h1);
      tick();
      bus.take_interrupt_i = 1'b0;
      check_model();
      chk("t4_exc",   {26'h0, bus.csr_writeback_exception_o}, 32'h20);
      chk("t4_pc",    bus.csr_writeback_exception_pc_o, 32'h100);
      chk("t4_write", {31'h0, bus.csr_writeback_write_o}, 32'h0);
      tick();

      // Stall with WB valid: nothing for three cycles, then one pulse
      issue(32'h400, 12'h340, 32'h0, 1'b1, 32'hABCD, 6'h0);
      step();
      idle();
      step();
      bus.stall_i = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
         check_model();
         chk("t5_stall_write", {31'h0, bus.csr_writeback_write_o}, 32'h0);
         tick();
      end
      bus.stall_i = 1'b0;
      check_model();
      chk("t5_pulse_pc", bus.csr_writeback_exception_pc_o, 32'h400);
      tick();
      check_model();
      chk("t5_once", {31'h0, bus.csr_writeback_write_o}, 32'h0);
      tick();

      // SATP write with fence: write and squash together
      issue(32'h500, 12'h180, 32'h0, 1'b1, 32'h8000_0001, 6'h34);
      step();
      idle();
      step();
      check_model();
      chk("t6_write",  {31'h0, bus.csr_writeback_write_o}, 32'h1);
      chk("t6_squash", {31'h0, bus.squash_o}, 32'h1);
      tick();

      // Reset while stalled with both stages full clears everything
      issue(32'h600, 12'h340, 32'h0, 1'b1, 32'h1, 6'h0);
      step();
      issue(32'h604, 12'h340, 32'h0, 1'b1, 32'h2, 6'h0);
      step();
      idle();
      bus.stall_i = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_model();
      chk("t6_rst_inhibit", {31'h0, bus.interrupt_inhibit_o}, 32'h0);
      tick();
      bus.stall_i = 1'b0;
      check_model();
      chk("t6_rst_pc", bus.csr_writeback_exception_pc_o, 32'h0);
      tick();

      // Randomised traffic against the model
      for (int unsigned n = 0; n < 400; n++) begin
         bus.e1_valid_i                = ($urandom_range(0, 3) != 0);
         bus.e1_pc_i                   = $urandom;
         bus.e1_opcode_i               = $urandom;
         bus.e1_badaddr_i              = $urandom;
         bus.csr_result_e1_value_i     = $urandom;
         bus.csr_result_e1_write_i     = ($urandom_range(0, 1) != 0);
         bus.csr_result_e1_wdata_i     = $urandom;
         bus.e1_exception_i            = ($urandom_range(0, 7) == 0) ? exc_pool[$urandom_range(0, 7)] : 6'h0;
         bus.csr_result_e1_exception_i = ($urandom_range(0, 7) == 0) ? exc_pool[$urandom_range(0, 7)] : 6'h0;
         bus.mem_exception_e2_i        = ($urandom_range(0, 7) == 0) ? exc_pool[$urandom_range(0, 7)] : 6'h0;
         bus.mem_badaddr_e2_i          = $urandom;
         bus.stall_i                   = ($urandom_range(0, 3) == 0);
         bus.take_interrupt_i          = ($urandom_range(0, 5) == 0);
         bus.branch_csr_request_i      = ($urandom_range(0, 15) == 0);
         rst                           = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
